uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the baud divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Rounded clk cycles per oversample tick.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered first-word-fall-through FIFO with occupancy count.
// A write while full is accepted only when a read frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count need a known state, and
  // the empty-gated read port keeps stale contents from ever reaching the output.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with majority-vote sampling, glitch-rejecting start
// detection and a FIFO-buffered valid/ready output carrying per-word error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUDRATE   = 115_200,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_frame_err,
  output logic                          m_parity_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clear_overrun,
  output logic                          rx_busy
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W   = $clog2(OVERSAMPLE);
  localparam int MID    = OVERSAMPLE / 2;
  localparam int WORD_W = DATA_BITS + 2;

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_fifo: OVERSAMPLE must be even and >= 4");
  end
  if (CLK_FREQ / (BAUDRATE * OVERSAMPLE) < 1) begin : g_bad_div
    $error("uart_rx_fifo: clock too slow for BAUDRATE*OVERSAMPLE");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
    $error("uart_rx_fifo: unsupported frame format");
  end

  rx_state_e            state_q, state_d;
  logic                 rx_meta, rx_sync, rx_prev;
  logic                 start_edge;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      tick_cnt;
  logic                 tick, samp_a, samp_b, vote, bit_end;
  logic                 s0, s1, voted;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 frame_err_q, parity_err_q;
  logic                 push_now, push_q;
  logic [WORD_W-1:0]    push_word_q, head_word;
  logic                 fifo_full, fifo_empty, pop, drop;

  // Synchroniser plus edge register; all idle-high so reset never looks like a start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev && !rx_sync;

  // Tick generator is held at zero in IDLE, so every frame starts phase-aligned to its edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if (state_q == ST_IDLE) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_cnt <= (tick_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt + 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  assign tick    = (div_cnt == DIV_W'(DIV - 1));
  assign samp_a  = tick && (tick_cnt == OS_W'(MID - 1));
  assign samp_b  = tick && (tick_cnt == OS_W'(MID));
  assign vote    = tick && (tick_cnt == OS_W'(MID + 1));
  assign bit_end = tick && (tick_cnt == OS_W'(OVERSAMPLE - 1));
  assign voted   = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    push_now = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (start_edge) state_d = ST_START;
      ST_START: begin
        if (vote && voted) state_d = ST_IDLE;
        else if (bit_end)  state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_cnt == 4'(DATA_BITS - 1))
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        // Leaving at mid-bit leaves half a bit to catch a back-to-back start edge.
        if (vote && stop_cnt == 1'(STOP_BITS - 1)) begin
          state_d  = ST_IDLE;
          push_now = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      shift_q      <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      push_q       <= 1'b0;
      push_word_q  <= '0;
    end else begin
      push_q <= push_now;
      if (push_now) push_word_q <= {frame_err_q | ~voted, parity_err_q, shift_q};
      if (samp_a) s0 <= rx_sync;
      if (samp_b) s1 <= rx_sync;
      unique case (state_q)
        ST_IDLE: begin
          bit_cnt      <= '0;
          stop_cnt     <= 1'b0;
          frame_err_q  <= 1'b0;
          parity_err_q <= 1'b0;
        end
        ST_DATA: begin
          if (vote)    shift_q <= {voted, shift_q[DATA_BITS-1:1]};
          if (bit_end) bit_cnt <= bit_cnt + 1'b1;
        end
        ST_PARITY: begin
          // Odd mode expects data+parity to XOR to 1, even mode to 0.
          if (vote) parity_err_q <= (PARITY == PAR_ODD) ? ~(^shift_q ^ voted) : (^shift_q ^ voted);
        end
        ST_STOP: begin
          if (vote && !voted) frame_err_q <= 1'b1;
          if (bit_end)        stop_cnt    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pop  = m_valid && m_ready;
  assign drop = push_q && fifo_full && !pop;

  // A drop in the same cycle as clear_overrun keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (clear_overrun) overrun <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push_q),
    .wr_data (push_word_q),
    .rd_en   (pop),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign {m_frame_err, m_parity_err, m_data} = head_word;
  assign m_valid = !fifo_empty;
  assign rx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: instance a uses defaults (8N1), instance b uses even parity.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS   = 104;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_a, rx_b;
  logic       m_ready_a, m_ready_b, clear_a, clear_b;
  logic [7:0] m_data_a, m_data_b;
  logic       ferr_a, ferr_b, perr_a, perr_b;
  logic       valid_a, valid_b, overrun_a, overrun_b, busy_a, busy_b;
  logic [4:0] count_a, count_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut_a (
    .clk (clk), .resetn (resetn), .rx (rx_a),
    .m_data (m_data_a), .m_frame_err (ferr_a), .m_parity_err (perr_a),
    .m_valid (valid_a), .m_ready (m_ready_a), .fifo_count (count_a),
    .overrun (overrun_a), .clear_overrun (clear_a), .rx_busy (busy_a)
  );

  uart_rx_fifo #(.PARITY (2)) dut_b (
    .clk (clk), .resetn (resetn), .rx (rx_b),
    .m_data (m_data_b), .m_frame_err (ferr_b), .m_parity_err (perr_b),
    .m_valid (valid_b), .m_ready (m_ready_b), .fifo_count (count_b),
    .overrun (overrun_b), .clear_overrun (clear_b), .rx_busy (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
    cycles(BIT_CLKS);
  endtask

  // par_bit < 0 means no parity bit on the line.
  task automatic send_frame(input int sel, input logic [7:0] data, input int par_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (par_bit >= 0) drive_bit(sel, par_bit[0]);
    drive_bit(sel, 1'b1);
  endtask

  task automatic pop_a();
    m_ready_a = 1'b1;
    cycles(1);
    m_ready_a = 1'b0;
  endtask

  task automatic pop_b();
    m_ready_b = 1'b1;
    cycles(1);
    m_ready_b = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1;
    m_ready_a = 1'b0; m_ready_b = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0;
    cycles(3);

    check("rst_valid",   valid_a,   1'b0);
    check("rst_count",   count_a,   5'd0);
    check("rst_overrun", overrun_a, 1'b0);
    check("rst_busy",    busy_a,    1'b0);
    check("rst_data",    m_data_a,  8'h00);
    check("rst_ferr",    ferr_a,    1'b0);
    check("rst_perr",    perr_a,    1'b0);
    resetn = 1'b1;
    cycles(5);

    // Plain 8N1 word.
    send_frame(0, 8'hA5, -1);
    cycles(10);
    check("a5_valid", valid_a,  1'b1);
    check("a5_data",  m_data_a, 8'hA5);
    check("a5_ferr",  ferr_a,   1'b0);
    check("a5_perr",  perr_a,   1'b0);
    check("a5_count", count_a,  5'd1);
    pop_a();
    check("a5_pop_count", count_a, 5'd0);
    check("a5_pop_valid", valid_a, 1'b0);

    // Even parity: 0x3C has four ones, so parity bit 1 is wrong and 0 is right.
    send_frame(1, 8'h3C, 1);
    cycles(10);
    check("par_bad_data", m_data_b, 8'h3C);
    check("par_bad_perr", perr_b,   1'b1);
    check("par_bad_ferr", ferr_b,   1'b0);
    pop_b();
    send_frame(1, 8'h3C, 0);
    cycles(10);
    check("par_ok_data", m_data_b, 8'h3C);
    check("par_ok_perr", perr_b,   1'b0);
    pop_b();
    check("par_count", count_b, 5'd0);

    // 30-clock glitch: start is detected, then rejected by the vote within one bit.
    rx_a = 1'b0;
    cycles(10);
    check("glitch_busy_hi", busy_a, 1'b1);
    cycles(20);
    rx_a = 1'b1;
    cycles(BIT_CLKS - 30);
    check("glitch_busy_lo", busy_a,  1'b0);
    check("glitch_count",   count_a, 5'd0);

    // 17 back-to-back frames into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) send_frame(0, 8'(i), -1);
    cycles(10);
    check("ovr_count",   count_a,   5'd16);
    check("ovr_flag",    overrun_a, 1'b1);
    check("ovr_head",    m_data_a,  8'h00);
    clear_a = 1'b1;
    cycles(1);
    clear_a = 1'b0;
    check("ovr_cleared", overrun_a, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), m_data_a, 32'(i));
      pop_a();
    end
    check("drain_count", count_a, 5'd0);
    check("drain_valid", valid_a, 1'b0);

    // Break: three frame times low gives exactly one framing-error word.
    rx_a = 1'b0;
    cycles(3 * FRAME_CLKS);
    check("brk_count", count_a,  5'd1);
    check("brk_data",  m_data_a, 8'h00);
    check("brk_ferr",  ferr_a,   1'b1);
    check("brk_busy",  busy_a,   1'b0);
    rx_a = 1'b1;
    cycles(BIT_CLKS);
    pop_a();
    send_frame(0, 8'h55, -1);
    cycles(10);
    check("post_brk_data",  m_data_a, 8'h55);
    check("post_brk_ferr",  ferr_a,   1'b0);
    check("post_brk_count", count_a,  5'd1);
    pop_a();

    // Reset pulse in the middle of the data bits of 0xFF.
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    resetn = 1'b0;
    cycles(2);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) drive_bit(0, 1'b1);
    cycles(10);
    check("rstmid_count", count_a, 5'd0);
    check("rstmid_busy",  busy_a,  1'b0);
    send_frame(0, 8'h12, -1);
    cycles(10);
    check("rstmid_next_data",  m_data_a, 8'h12);
    check("rstmid_next_count", count_a,  5'd1);
    check("rstmid_next_ferr",  ferr_a,   1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
